// File: rtl/msrv32_wb_ctrl_pipe_if.sv
// Handshake and payload bundle between stage 2 and the write-back control
// register. The slave side is the pipeline register. The master side is the
// producer/consumer pair around it.
interface msrv32_wb_ctrl_pipe_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              valid_in;
  logic              ready_out;
  logic              rf_wr_en_in;
  logic              csr_wr_en_in;
  logic [4:0]        rd_addr_in;
  logic [CSR_AW-1:0] csr_addr_in;
  logic [2:0]        wb_mux_sel_in;
  logic [2:0]        csr_op_in;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   alu_result_in;
  logic              ready_in;
  logic              valid_out;
  logic              rf_wr_en_reg_out;
  logic              csr_wr_en_reg_out;
  logic [4:0]        rd_addr_reg_out;
  logic [CSR_AW-1:0] csr_addr_reg_out;
  logic [2:0]        wb_mux_sel_reg_out;
  logic [2:0]        csr_op_reg_out;
  logic [XLEN-1:0]   pc_reg_out;
  logic [XLEN-1:0]   alu_result_reg_out;
  logic              instret_inc_out;

  modport slave (
    input  valid_in, rf_wr_en_in, csr_wr_en_in, rd_addr_in, csr_addr_in,
           wb_mux_sel_in, csr_op_in, pc_in, alu_result_in, ready_in,
    output ready_out, valid_out, rf_wr_en_reg_out, csr_wr_en_reg_out,
           rd_addr_reg_out, csr_addr_reg_out, wb_mux_sel_reg_out,
           csr_op_reg_out, pc_reg_out, alu_result_reg_out, instret_inc_out
  );

  modport master (
    output valid_in, rf_wr_en_in, csr_wr_en_in, rd_addr_in, csr_addr_in,
           wb_mux_sel_in, csr_op_in, pc_in, alu_result_in, ready_in,
    input  ready_out, valid_out, rf_wr_en_reg_out, csr_wr_en_reg_out,
           rd_addr_reg_out, csr_addr_reg_out, wb_mux_sel_reg_out,
           csr_op_reg_out, pc_reg_out, alu_result_reg_out, instret_inc_out
  );
endinterface

// File: rtl/msrv32_wb_ctrl_pipe.sv
// Stage-2 to write-back control register, built as a 2-entry skid buffer.
// MAIN drives the outputs. SKID catches one entry while downstream stalls, so
// ready_out depends only on registered state. Flush kills both entries.
module msrv32_wb_ctrl_pipe #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_in,
  input  logic                flush_in,
  msrv32_wb_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic              rf_wr_en;
    logic              csr_wr_en;
    logic [4:0]        rd_addr;
    logic [CSR_AW-1:0] csr_addr;
    logic [2:0]        wb_mux_sel;
    logic [2:0]        csr_op;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu_result;
  } entry_t;

  entry_t in_ent;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   drain;

  assign in_ent = {bus.rf_wr_en_in, bus.csr_wr_en_in, bus.rd_addr_in,
                   bus.csr_addr_in, bus.wb_mux_sel_in, bus.csr_op_in,
                   bus.pc_in, bus.alu_result_in};

  assign bus.ready_out = !skid_valid_q;
  assign accept        = bus.valid_in & !skid_valid_q & !flush_in;
  assign drain         = main_valid_q & bus.ready_in;

  // Next-state for both entries. SKID is always older than the input, so it
  // refills MAIN first. SKID empties before the block accepts again.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_in) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = in_ent;
        main_valid_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_ent;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  // Entry registers. Reset clears the valid bits and the payload.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.valid_out          = main_valid_q;
  assign bus.rf_wr_en_reg_out   = main_valid_q & main_q.rf_wr_en;
  assign bus.csr_wr_en_reg_out  = main_valid_q & main_q.csr_wr_en;
  assign bus.rd_addr_reg_out    = main_q.rd_addr;
  assign bus.csr_addr_reg_out   = main_q.csr_addr;
  assign bus.wb_mux_sel_reg_out = main_q.wb_mux_sel;
  assign bus.csr_op_reg_out     = main_q.csr_op;
  assign bus.pc_reg_out         = main_q.pc;
  assign bus.alu_result_reg_out = main_q.alu_result;
  // Retire only on a real hand-off. Flush and reset both suppress the pulse.
  assign bus.instret_inc_out    = drain & !flush_in & !ms_riscv32_mp_rst_in;

endmodule
